// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding load/store responder with a programmable access latency.
// Optional build macro DMEM_MISALIGN_TRAP_EN: reject misaligned half/word accesses instead of aligning them.
module dmem_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  write_ram_flag,
    input  logic [2:0]  read_ram_flag,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [AW+1:0]     addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [1:0]        wflag_q, wflag_d;
    logic [2:0]        rflag_q, rflag_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [31:0]       mem_q [DEPTH_WORDS];

    logic [AW-1:0]     word_idx_s;
    logic [1:0]        lane_s;
    logic [31:0]       cur_word_s;
    logic [31:0]       new_word_s;
    logic [31:0]       load_s;
    logic              trap_s;
    logic              err_s;
    logic              mem_we_s;
    logic              unused_addr_s;

    function automatic logic [31:0] store_merge(input logic [31:0] old_w, input logic [31:0] wd,
                                                input logic [1:0] wf, input logic [1:0] lane);
        logic [31:0] res;
        res = old_w;
        case (wf)
            2'b01:   res[{lane, 3'b000} +: 8]     = wd[7:0];
            2'b10:   res[{lane[1], 4'b0000} +: 16] = wd[15:0];
            2'b11:   res = wd;
            default: res = old_w;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] w, input logic [2:0] rf,
                                                input logic [1:0] lane);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = w[{lane, 3'b000} +: 8];
        h = w[{lane[1], 4'b0000} +: 16];
        case (rf)
            3'b001:  res = {{24{b[7]}}, b};
            3'b010:  res = {24'h000000, b};
            3'b011:  res = {{16{h[15]}}, h};
            3'b100:  res = {16'h0000, h};
            3'b101:  res = w;
            default: res = 32'h0000_0000;
        endcase
        return res;
    endfunction

`ifdef DMEM_MISALIGN_TRAP_EN
    // Access size comes from the store flag when one is present, since the store wins.
    function automatic logic is_misaligned(input logic [1:0] wf, input logic [2:0] rf,
                                           input logic [1:0] lane);
        logic half, word;
        half = (wf == 2'b10) || ((wf == 2'b00) && ((rf == 3'b011) || (rf == 3'b100)));
        word = (wf == 2'b11) || ((wf == 2'b00) && (rf == 3'b101));
        return (half && lane[0]) || (word && (lane != 2'b00));
    endfunction
`endif

    assign unused_addr_s = ^req_addr[31:AW+2];
    assign req_ready     = (state_q == IDLE);
    assign resp_valid    = (state_q == RESP);
    assign resp_rdata    = rdata_q;
    assign resp_err      = err_q;

    // Datapath for the latched request: lane merge, load extension and error decode.
    always_comb begin
        word_idx_s = addr_q[AW+1:2];
        lane_s     = addr_q[1:0];
        cur_word_s = mem_q[word_idx_s];
`ifdef DMEM_MISALIGN_TRAP_EN
        trap_s     = is_misaligned(wflag_q, rflag_q, lane_s);
`else
        trap_s     = 1'b0;
`endif
        new_word_s = store_merge(cur_word_s, wdata_q, wflag_q, lane_s);
        err_s      = trap_s || ((wflag_q != 2'b00) && (rflag_q != 3'b000));
        if (trap_s || (wflag_q != 2'b00)) begin
            load_s = 32'h0000_0000;
        end else begin
            load_s = load_extend(cur_word_s, rflag_q, lane_s);
        end
    end

    // Next-state logic: accept in IDLE, count down in BUSY, hold the response in RESP.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wflag_d  = wflag_q;
        rflag_d  = rflag_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        mem_we_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = BUSY;
                    cnt_d   = LAT_M1;
                    addr_d  = req_addr[AW+1:0];
                    wdata_d = req_wdata;
                    wflag_d = write_ram_flag;
                    rflag_d = read_ram_flag;
                    rdata_d = 32'h0000_0000;
                    err_d   = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d  = RESP;
                    mem_we_s = (wflag_q != 2'b00) && !trap_s;
                    rdata_d  = load_s;
                    err_d    = err_s;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and latched-request registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            wdata_q <= 32'h0000_0000;
            wflag_q <= 2'b00;
            rflag_q <= 3'b000;
            rdata_q <= 32'h0000_0000;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wflag_q <= wflag_d;
            rflag_q <= rflag_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Word storage; a store lands only on the final BUSY edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem_q[i] <= 32'h0000_0000;
            end
        end else if (mem_we_s) begin
            mem_q[word_idx_s] <= new_word_s;
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed requests with expected responses queued for an independent monitor.
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [1:0]  write_ram_flag = 2'b00;
    logic [2:0]  read_ram_flag = 3'b000;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int acc_cyc  = 0;
    bit seen_valid = 1'b0;
    logic [32:0] exp_q [$];

    dmem_responder dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_wdata(req_wdata), .write_ram_flag(write_ram_flag),
        .read_ram_flag(read_ram_flag), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%09h, expected 0x%09h", name, act, exp);
        end
    endtask

    // Monitor: sample mid-cycle, track latency, compare against the scoreboard head.
    always @(negedge clk) begin
        if (!rst && req_valid && req_ready) begin
            acc_cyc = cyc + 1;
        end
        if (resp_valid) begin
            if (!seen_valid) begin
                check("latency", 33'(cyc - acc_cyc), 33'd2);
                seen_valid = 1'b1;
            end
            if (exp_q.size() == 0) begin
                check("unexpected_resp", {resp_err, resp_rdata}, 33'h1_FFFF_FFFF);
            end else begin
                check("resp", {resp_err, resp_rdata}, exp_q[0]);
                if (resp_ready) begin
                    void'(exp_q.pop_front());
                    seen_valid = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] addr, input logic [31:0] wd, input logic [1:0] wf,
                        input logic [2:0] rf, input logic [31:0] exp_rd, input logic exp_err);
        int n;
        req_valid = 1'b1;
        req_addr = addr;
        req_wdata = wd;
        write_ram_flag = wf;
        read_ram_flag = rf;
        n = 0;
        while (!req_ready && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) begin
            check("accept_timeout", 33'(n), 33'd0);
        end else begin
            exp_q.push_back({exp_err, exp_rd});
        end
        tick();
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || resp_valid) && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) check("drain_timeout", 33'(n), 33'd0);
    endtask

    initial begin
        #1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("reset_req_ready", 33'(req_ready), 33'd1);
        check("reset_resp_valid", 33'(resp_valid), 33'd0);
        check("reset_rdata_err", {resp_err, resp_rdata}, 33'd0);

        send(32'h10, 32'h0, 2'b00, 3'b101, 32'h0000_0000, 1'b0);
        send(32'h8, 32'h8000_00F1, 2'b11, 3'b000, 32'h0, 1'b0);
        send(32'h8, 32'h0, 2'b00, 3'b001, 32'hFFFF_FFF1, 1'b0);
        send(32'h8, 32'h0, 2'b00, 3'b010, 32'h0000_00F1, 1'b0);
        send(32'hA, 32'h0, 2'b00, 3'b011, 32'hFFFF_8000, 1'b0);
        send(32'hA, 32'h0, 2'b00, 3'b100, 32'h0000_8000, 1'b0);
        send(32'h4, 32'h1122_3344, 2'b11, 3'b000, 32'h0, 1'b0);
        send(32'h5, 32'hFFFF_FFAB, 2'b01, 3'b000, 32'h0, 1'b0);
        send(32'h4, 32'h0, 2'b00, 3'b101, 32'h1122_AB44, 1'b0);
        send(32'h12, 32'h5555_CAFE, 2'b10, 3'b000, 32'h0, 1'b0);
        send(32'h10, 32'h0, 2'b00, 3'b101, 32'hCAFE_0000, 1'b0);
        send(32'h12, 32'h0, 2'b00, 3'b011, 32'hFFFF_CAFE, 1'b0);
        drain();

        // Backpressure: response must hold while a competing request is ignored.
        resp_ready = 1'b0;
        send(32'h8, 32'h0, 2'b00, 3'b101, 32'h8000_00F1, 1'b0);
        for (int i = 0; i < 10 && !resp_valid; i++) tick();
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1;
            req_addr = 32'h4;
            read_ram_flag = 3'b101;
            write_ram_flag = 2'b00;
            check("hold_req_ready", {req_ready, resp_valid, 31'd0}, {1'b0, 1'b1, 31'd0});
            tick();
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        tick();
        check("release_idle", {req_ready, resp_valid, 31'd0}, {1'b1, 1'b0, 31'd0});
        drain();

`ifdef DMEM_MISALIGN_TRAP_EN
        send(32'h6, 32'hA5A5_A5A5, 2'b11, 3'b000, 32'h0, 1'b1);
        send(32'h4, 32'h0, 2'b00, 3'b101, 32'h1122_AB44, 1'b0);
        send(32'h9, 32'h0, 2'b00, 3'b011, 32'h0, 1'b1);
`else
        send(32'h6, 32'hA5A5_A5A5, 2'b11, 3'b000, 32'h0, 1'b0);
        send(32'h4, 32'h0, 2'b00, 3'b101, 32'hA5A5_A5A5, 1'b0);
        send(32'h9, 32'h0, 2'b00, 3'b011, 32'h0000_00F1, 1'b0);
`endif
        send(32'h14, 32'h1234_5678, 2'b11, 3'b101, 32'h0, 1'b1);
        send(32'h14, 32'h0, 2'b00, 3'b101, 32'h1234_5678, 1'b0);
        send(32'h14, 32'hFFFF_FFFF, 2'b00, 3'b000, 32'h0, 1'b0);
        send(32'h14, 32'h0, 2'b00, 3'b110, 32'h0, 1'b0);
        send(32'h108, 32'h0, 2'b00, 3'b101, 32'h8000_00F1, 1'b0);
        drain();

        // Reset in the middle of a store: nothing committed, no response.
        req_valid = 1'b1;
        req_addr = 32'h0;
        req_wdata = 32'hDEAD_BEEF;
        write_ram_flag = 2'b11;
        read_ram_flag = 3'b000;
        check("pre_reset_ready", 33'(req_ready), 33'd1);
        tick();
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("midreset_idle", {req_ready, resp_valid, 31'd0}, {1'b1, 1'b0, 31'd0});
        tick();
        rst = 1'b0;
        tick();
        send(32'h0, 32'h0, 2'b00, 3'b101, 32'h0, 1'b0);
        send(32'h8, 32'h0, 2'b00, 3'b101, 32'h0, 1'b0);
        drain();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
